// File: rtl/candidate_collector_pkg.sv
// Shared decoder definitions: default widths/sizes for the candidate
// filter stages and the candidate collector state encoding.
package candidate_collector_pkg;

   localparam int Q_WIDTH_DEFAULT   = 6;
   localparam int LLR_WIDTH_DEFAULT = 5;
   localparam int NM_DEFAULT        = 16;
   localparam int CNT_WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      SKIP    = 2'd1,
      DRAIN   = 2'd2
   } collector_state_t;

endpackage

// File: rtl/candidate_collector.sv
// Candidate collector: stores up to Nm unique candidates of one list
// (arriving in non-decreasing LLR order), then drains them to the
// downstream stage with LLRs normalised against the first entry.
module candidate_collector
   import candidate_collector_pkg::*;
#(
   parameter int Q_Width   = Q_WIDTH_DEFAULT,
   parameter int LLR_Width = LLR_WIDTH_DEFAULT,
   parameter int Nm        = NM_DEFAULT,
   parameter int Cnt_Width = CNT_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 In_Save,
   input  logic [Q_Width:0]     In_Q,
   input  logic [LLR_Width:0]   In_LLR,
   input  logic                 In_Last,
   output logic                 Busy,
   output logic                 Out_Valid,
   input  logic                 Out_Ready,
   output logic [Q_Width:0]     Out_Q,
   output logic [LLR_Width:0]   Out_LLR,
   output logic                 Out_Last,
   output logic                 Empty_Pulse
);

   localparam int Addr_Width = (Nm > 1) ? $clog2(Nm) : 1;

   typedef logic [Cnt_Width:0] cnt_t;

   collector_state_t state;
   cnt_t             count;
   cnt_t             rd_ptr;
   cnt_t             count_next;

   logic [Q_Width:0]   q_mem   [Nm];
   logic [LLR_Width:0] llr_mem [Nm];

   logic                  write_en;
   logic                  drain_active;
   logic                  transfer;
   logic                  last_entry;
   logic [Addr_Width-1:0] wr_addr;
   logic [Addr_Width-1:0] rd_addr;
   logic [LLR_Width:0]    rd_llr;
   logic [LLR_Width:0]    base_llr;

   assign write_en     = (state == COLLECT) && In_Save;
   assign count_next   = count + cnt_t'(write_en);
   assign wr_addr      = count[Addr_Width-1:0];
   assign rd_addr      = rd_ptr[Addr_Width-1:0];
   assign drain_active = (state == DRAIN);
   assign transfer     = drain_active && Out_Ready;
   assign last_entry   = (rd_ptr == (count - cnt_t'(1)));

   // Output presentation is a pure decode of registered state and storage,
   // so it stays stable for as long as the consumer stalls.
   assign rd_llr      = llr_mem[rd_addr];
   assign base_llr    = llr_mem[0];
   assign Busy        = (state != COLLECT);
   assign Out_Valid   = drain_active;
   assign Out_Last    = drain_active && last_entry;
   assign Out_Q       = drain_active ? q_mem[rd_addr] : '0;
   assign Out_LLR     = (drain_active && (rd_llr >= base_llr)) ? (rd_llr - base_llr) : '0;

   // Candidate storage; written only while collecting, never cleared.
   always_ff @(posedge clk) begin
      if (!rst && write_en) begin
         q_mem[wr_addr]   <= In_Q;
         llr_mem[wr_addr] <= In_LLR;
      end
   end

   // Collect / skip-overflow / drain sequencing with list bookkeeping.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= COLLECT;
         count       <= '0;
         rd_ptr      <= '0;
         Empty_Pulse <= 1'b0;
      end else begin
         Empty_Pulse <= 1'b0;
         unique case (state)
            COLLECT: begin
               count <= count_next;
               if (write_en && (count_next == cnt_t'(Nm))) begin
                  state <= In_Last ? DRAIN : SKIP;
               end else if (In_Last) begin
                  if (count_next != '0) begin
                     state <= DRAIN;
                  end else begin
                     Empty_Pulse <= 1'b1;
                  end
               end
            end
            SKIP: begin
               if (In_Last) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (transfer) begin
                  if (last_entry) begin
                     rd_ptr <= '0;
                     count  <= '0;
                     state  <= COLLECT;
                  end else begin
                     rd_ptr <= rd_ptr + cnt_t'(1);
                  end
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_candidate_collector.sv
// Self-checking bench for candidate_collector using an expected-entry
// scoreboard filled when a list is closed and consumed on each handshake.
module tb_candidate_collector;

   localparam int QW = 7;
   localparam int LW = 6;
   localparam int NM = 16;

   typedef struct {
      logic [QW-1:0] q;
      logic [LW-1:0] llr;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          In_Save;
   logic [QW-1:0] In_Q;
   logic [LW-1:0] In_LLR;
   logic          In_Last;
   logic          Busy;
   logic          Out_Valid;
   logic          Out_Ready;
   logic [QW-1:0] Out_Q;
   logic [LW-1:0] Out_LLR;
   logic          Out_Last;
   logic          Empty_Pulse;

   exp_t          sb[$];
   logic [QW-1:0] mq[$];
   logic [LW-1:0] ml[$];
   logic          m_skip;
   logic          m_closed;

   int check_count = 0;
   int pass_count  = 0;

   candidate_collector dut (
      .clk         (clk),
      .rst         (rst),
      .In_Save     (In_Save),
      .In_Q        (In_Q),
      .In_LLR      (In_LLR),
      .In_Last     (In_Last),
      .Busy        (Busy),
      .Out_Valid   (Out_Valid),
      .Out_Ready   (Out_Ready),
      .Out_Q       (Out_Q),
      .Out_LLR     (Out_LLR),
      .Out_Last    (Out_Last),
      .Empty_Pulse (Empty_Pulse)
   );

   always #5 clk = ~clk;

   // Count one comparison and report it when it does not match.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Turn the collected model list into expected drain entries.
   task automatic closeList();
      for (int i = 0; i < mq.size(); i++) begin
         exp_t e;
         e.q    = mq[i];
         e.llr  = (ml[i] >= ml[0]) ? ml[i] - ml[0] : '0;
         e.last = (i == mq.size() - 1);
         sb.push_back(e);
      end
      mq.delete();
      ml.delete();
      m_closed = 1'b1;
   endtask

   // Drive one input cycle, update the model, and check the control outputs.
   task automatic applyStimulus(input logic save, input logic [QW-1:0] q, input logic [LW-1:0] llr, input logic last);
      logic exp_empty;
      exp_empty = 1'b0;
      In_Save = save;
      In_Q    = q;
      In_LLR  = llr;
      In_Last = last;
      if (!m_skip) begin
         if (save) begin
            mq.push_back(q);
            ml.push_back(llr);
         end
         if (save && mq.size() == NM) begin
            if (last) closeList();
            else m_skip = 1'b1;
         end else if (last) begin
            if (mq.size() > 0) closeList();
            else exp_empty = 1'b1;
         end
      end else if (last) begin
         m_skip = 1'b0;
         closeList();
      end
      tick();
      In_Save = 1'b0;
      In_Last = 1'b0;
      checkOutput("busy", Busy, m_skip || m_closed);
      checkOutput("valid", Out_Valid, m_closed);
      checkOutput("empty_pulse", Empty_Pulse, exp_empty);
   endtask

   // Drain the pending list with a 4-cycle ready pattern, checking each
   // transferred entry and output stability across stalls.
   task automatic drainList(input logic [3:0] pat, input logic junk);
      int            cyc;
      logic          stalled;
      logic [QW-1:0] hq;
      logic [LW-1:0] hl;
      logic          hlast;
      exp_t          e;
      cyc     = 0;
      stalled = 1'b0;
      hq      = '0;
      hl      = '0;
      hlast   = 1'b0;
      In_Save = junk;
      In_Last = junk;
      In_Q    = 7'h7f;
      In_LLR  = 6'h00;
      while (sb.size() > 0 && cyc < 200) begin
         Out_Ready = pat[cyc % 4];
         if (stalled) begin
            checkOutput("stall_q", Out_Q, hq);
            checkOutput("stall_llr", Out_LLR, hl);
            checkOutput("stall_last", Out_Last, hlast);
         end
         if (Out_Valid && Out_Ready) begin
            e = sb.pop_front();
            checkOutput("out_q", Out_Q, e.q);
            checkOutput("out_llr", Out_LLR, e.llr);
            checkOutput("out_last", Out_Last, e.last);
            stalled = 1'b0;
         end else if (Out_Valid) begin
            hq      = Out_Q;
            hl      = Out_LLR;
            hlast   = Out_Last;
            stalled = 1'b1;
         end else begin
            checkOutput("drain_valid", Out_Valid, 1);
         end
         tick();
         cyc++;
      end
      if (sb.size() > 0) begin
         checkOutput("drain_timeout", sb.size(), 0);
         sb.delete();
      end
      In_Save   = 1'b0;
      In_Last   = 1'b0;
      Out_Ready = 1'b0;
      m_closed  = 1'b0;
      checkOutput("busy_after_drain", Busy, 0);
      checkOutput("valid_after_drain", Out_Valid, 0);
   endtask

   initial begin
      logic [LW-1:0] llr5 [5];
      exp_t          e;
      llr5 = '{6'd3, 6'd4, 6'd4, 6'd7, 6'd9};
      rst       = 1'b1;
      In_Save   = 1'b0;
      In_Q      = '0;
      In_LLR    = '0;
      In_Last   = 1'b0;
      Out_Ready = 1'b0;
      m_skip    = 1'b0;
      m_closed  = 1'b0;
      tick();
      tick();
      checkOutput("rst_busy", Busy, 0);
      checkOutput("rst_valid", Out_Valid, 0);
      checkOutput("rst_last", Out_Last, 0);
      checkOutput("rst_empty", Empty_Pulse, 0);
      checkOutput("rst_q", Out_Q, 0);
      checkOutput("rst_llr", Out_LLR, 0);
      rst = 1'b0;
      tick();

      $display("[TB] five entries, In_Last alone");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 7'(10 + i), llr5[i], 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b1);
      drainList(4'b1111, 1'b0);

      $display("[TB] overflow into skip");
      for (int i = 0; i < 20; i++) applyStimulus(1'b1, 7'(i + 1), 6'(i), i == 19);
      drainList(4'b1111, 1'b0);

      $display("[TB] empty list");
      applyStimulus(1'b0, '0, '0, 1'b1);
      applyStimulus(1'b0, '0, '0, 1'b0);

      $display("[TB] last with third save, inputs ignored while draining");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 7'(40 + i), 6'(2 * i + 1), i == 2);
      drainList(4'b1111, 1'b1);

      $display("[TB] stalls during drain");
      for (int i = 0; i < 5; i++) applyStimulus(1'b1, 7'(60 + i), 6'(5 + i), i == 4);
      drainList(4'b1001, 1'b0);

      $display("[TB] exactly Nm entries with In_Last on the last write");
      for (int i = 0; i < NM; i++) applyStimulus(1'b1, 7'(80 + i), 6'(20 + i), i == NM - 1);
      drainList(4'b0110, 1'b0);

      $display("[TB] LLR normalisation saturates at zero");
      applyStimulus(1'b1, 7'd5, 6'd10, 1'b0);
      applyStimulus(1'b1, 7'd6, 6'd5, 1'b0);
      applyStimulus(1'b1, 7'd7, 6'd12, 1'b1);
      drainList(4'b1111, 1'b0);

      $display("[TB] reset during drain");
      for (int i = 0; i < 3; i++) applyStimulus(1'b1, 7'(100 + i), 6'(i), 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b1);
      Out_Ready = 1'b1;
      e = sb.pop_front();
      checkOutput("pre_rst_q", Out_Q, e.q);
      tick();
      e = sb.pop_front();
      checkOutput("pre_rst_q2", Out_Q, e.q);
      rst       = 1'b1;
      Out_Ready = 1'b0;
      tick();
      rst = 1'b0;
      sb.delete();
      m_closed = 1'b0;
      checkOutput("mid_rst_valid", Out_Valid, 0);
      checkOutput("mid_rst_busy", Busy, 0);
      checkOutput("mid_rst_q", Out_Q, 0);
      tick();
      checkOutput("post_rst_valid", Out_Valid, 0);
      applyStimulus(1'b1, 7'd120, 6'd8, 1'b0);
      applyStimulus(1'b1, 7'd121, 6'd11, 1'b1);
      drainList(4'b1111, 1'b0);

      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
